sof_frame_timer: RTL and testbench
==================================

Name: sof_frame_timer

Overview:
Frame scheduler directly upstream of the host SIE. It generates the frame-start request and frame number that the packet encoder consumes, and handshakes on the encoder's completion pulse. It also flags the end-of-frame guard window, during which the transfer scheduler must not launch new tokens. It reports frame rollover and SOF handshake timeouts to the UHCI register block.

Parameters:
FRAME_CYCLES, 60000, clk cycles per frame (1 ms at 60 MHz UTMI clock); must be ≥ 256
EOF_GUARD, 1500, cycles before frame end in which eof_window is asserted; must be < FRAME_CYCLES
SOF_TIMEOUT, 255, max cycles sof stays high without sof_done; must be ≥ 1

Ports:
clk  input  1  UTMI-domain clock
reset  input  1  asynchronous, active-low reset
run  input  1  UHCI run/stop bit; 1 = schedule frames
frnum_load  input  1  one-cycle strobe: load frame number
frnum_load_val  input  11  value loaded by frnum_load
sof_done  input  1  SIE pulse: SOF packet fully transmitted
sof  output  1  SOF request level to the SIE
frame_no  output  11  current frame number, stable while sof=1
frame_start  output  1  one-cycle pulse on each SOF_REQ entry
eof_window  output  1  end-of-frame guard active
frame_rollover  output  1  one-cycle pulse when frame_no wraps 2047→0
sof_timeout_err  output  1  one-cycle pulse on SOF handshake timeout
cycles_left  output  16  remaining cycles in the current frame

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output 0; internal down-counter and timeout counter are 0. Assertion mid-frame aborts immediately, with no final SOF.
- States: IDLE, SOF_REQ, FRAME_RUN.
- IDLE:
  - run=1 → SOF_REQ on the next edge. sof and frame_start are high in the cycle after run is sampled high.
  - Down-counter loads FRAME_CYCLES-1.
  - frnum_load is honoured only in IDLE, with frame_no updated on the next edge. It is ignored in other states.
- SOF_REQ:
  - sof=1 and the timeout counter increments.
  - sof_done=1 → FRAME_RUN; sof drops the cycle after sof_done.
  - timeout counter reaching SOF_TIMEOUT → FRAME_RUN with a sof_timeout_err pulse.
  - If the down-counter reaches 0 first, it is treated as a timeout.
- FRAME_RUN: down-counter decrements each cycle.
- Frame boundary (down-counter==0 in SOF_REQ or FRAME_RUN):
  - frame_no increments modulo 2048; frame_rollover pulses on 2047→0.
  - Down-counter reloads FRAME_CYCLES-1.
  - run=1 → SOF_REQ; run=0 → IDLE.
  - run falling mid-frame therefore finishes the current frame before stopping.
- The down-counter runs in SOF_REQ and FRAME_RUN, so frame length is exactly FRAME_CYCLES regardless of sof_done latency.
- sof_done arriving outside SOF_REQ is ignored.
- eof_window = (state≠IDLE) && (down-counter < EOF_GUARD), registered. It deasserts on the reload cycle.
- cycles_left = down-counter, zero-extended to 16 bits; 0 in IDLE.
- Counter width = $clog2(FRAME_CYCLES+192).
- frame_start, frame_rollover and sof_timeout_err are single-cycle registered pulses.

Optional Feature:
SOF_FRAME_ADJ_EN
- Defined: adds input sof_modify[7:0] (UHCI SOFMOD equivalent). Each frame length is FRAME_CYCLES + sof_modify − 64, with sof_modify sampled at each reload. A change mid-frame takes effect at the next frame.
- Undefined: the port is absent and frame length is fixed at FRAME_CYCLES.

Decomposition:
- Package usb_host_pkg holds:
  - the state enum (IDLE, SOF_REQ, FRAME_RUN);
  - FRAME_NO_W=11;
  - default constants for FRAME_CYCLES, EOF_GUARD and SOF_TIMEOUT;
  - SOFMOD_DEFAULT=64.
- One natural sub-module: frame_down_counter. It is a loadable down-counter with zero flag and reload-value input, and it isolates the SOF_FRAME_ADJ_EN length arithmetic.

Test Plan (FRAME_CYCLES=100, EOF_GUARD=10, SOF_TIMEOUT=8):
1. Reset release, run=1 at cycle 0 → sof=1 and frame_start at cycle 1, frame_no=0. sof_done at cycle 4 → sof=0 at cycle 5; next frame_start exactly 100 cycles after the first, with frame_no=1.
2. Counter at 9 → eof_window=1 until the reload cycle, then 0; eof_window stays 0 while run=0 in IDLE.
3. sof_done never arrives → sof high 8 cycles, sof_timeout_err pulses once, state FRAME_RUN; frame length is still 100.
4. frnum_load=1 with 2047 in IDLE, then run → frame_no=2047. At the next boundary frame_no=0 with a one-cycle frame_rollover pulse.
5. run drops at cycle 50 of a frame → frame completes, no further sof, state IDLE, cycles_left=0. frnum_load during FRAME_RUN is ignored.
6. reset asserted while sof=1 → all outputs 0 asynchronously. With SOF_FRAME_ADJ_EN and sof_modify=74, frame length is 110.

Source files
------------

// File: rtl/usb_host_pkg.sv
// Shared types and defaults for the USB host frame scheduler.
package usb_host_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOF_REQ   = 2'd1,
    FRAME_RUN = 2'd2
  } frame_state_e;

  localparam int FRAME_NO_W           = 11;
  localparam int DEF_FRAME_CYCLES     = 60000;
  localparam int DEF_EOF_GUARD        = 1500;
  localparam int DEF_SOF_TIMEOUT      = 255;
  localparam int SOFMOD_DEFAULT       = 64;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame-length down-counter with zero flag; owns the SOF_FRAME_ADJ_EN
// frame-length arithmetic (sof_modify sampled whenever the counter reloads).
module frame_down_counter
  import usb_host_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int CNT_W        = $clog2(DEF_FRAME_CYCLES + 192)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
`ifdef SOF_FRAME_ADJ_EN
  input  logic [7:0]       sof_modify,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero
);

  logic [CNT_W-1:0] reload_val;

`ifdef SOF_FRAME_ADJ_EN
  // Frame length is FRAME_CYCLES + sof_modify - 64; counter runs length-1 .. 0.
  assign reload_val = CNT_W'(FRAME_CYCLES - 1 - SOFMOD_DEFAULT + int'(sof_modify));
`else
  assign reload_val = CNT_W'(FRAME_CYCLES - 1);
`endif

  assign zero = (cnt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = reload_val;
    else if (dec)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/sof_frame_timer.sv
// USB host frame scheduler: SOF request/handshake, frame numbering, EOF guard.
// Optional macro SOF_FRAME_ADJ_EN adds the sof_modify frame-length trim input.
module sof_frame_timer
  import usb_host_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int EOF_GUARD    = DEF_EOF_GUARD,
  parameter int SOF_TIMEOUT  = DEF_SOF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  frnum_load,
  input  logic [FRAME_NO_W-1:0] frnum_load_val,
  input  logic                  sof_done,
`ifdef SOF_FRAME_ADJ_EN
  input  logic [7:0]            sof_modify,
`endif
  output logic                  sof,
  output logic [FRAME_NO_W-1:0] frame_no,
  output logic                  frame_start,
  output logic                  eof_window,
  output logic                  frame_rollover,
  output logic                  sof_timeout_err,
  output logic [15:0]           cycles_left
);

  localparam int CNT_W = $clog2(FRAME_CYCLES + 192);
  localparam int TO_W  = $clog2(SOF_TIMEOUT + 1);

  frame_state_e     state;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_zero;
  logic             active;
  logic             boundary;
  logic             active_nxt;

  assign active   = (state != IDLE);
  assign boundary = active && cnt_zero;
  // The counter is held at its reload value in IDLE so a frame starts full-length.
  frame_down_counter #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load       (!active || cnt_zero),
    .dec        (active),
`ifdef SOF_FRAME_ADJ_EN
    .sof_modify (sof_modify),
`endif
    .cnt        (cnt),
    .cnt_nxt    (cnt_nxt),
    .zero       (cnt_zero)
  );

  // eof_window is registered from next-cycle values so it lines up with cycles_left.
  assign active_nxt  = run || (active && !cnt_zero);
  assign cycles_left = active ? 16'(cnt) : 16'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      to_cnt          <= '0;
      sof             <= 1'b0;
      frame_no        <= '0;
      frame_start     <= 1'b0;
      eof_window      <= 1'b0;
      frame_rollover  <= 1'b0;
      sof_timeout_err <= 1'b0;
    end else begin
      frame_start     <= 1'b0;
      frame_rollover  <= 1'b0;
      sof_timeout_err <= 1'b0;
      eof_window      <= active_nxt && (cnt_nxt < CNT_W'(EOF_GUARD));

      if (boundary) begin
        frame_no       <= frame_no + 1'b1;
        frame_rollover <= (frame_no == '1);
        to_cnt         <= '0;
        // A frame ending before the SIE acknowledged its SOF counts as a timeout.
        if (state == SOF_REQ && !sof_done)
          sof_timeout_err <= 1'b1;
        if (run) begin
          state       <= SOF_REQ;
          sof         <= 1'b1;
          frame_start <= 1'b1;
        end else begin
          state <= IDLE;
          sof   <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            to_cnt <= '0;
            if (frnum_load)
              frame_no <= frnum_load_val;
            if (run) begin
              state       <= SOF_REQ;
              sof         <= 1'b1;
              frame_start <= 1'b1;
            end
          end
          SOF_REQ: begin
            if (sof_done) begin
              state  <= FRAME_RUN;
              sof    <= 1'b0;
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(SOF_TIMEOUT - 1)) begin
              state           <= FRAME_RUN;
              sof             <= 1'b0;
              to_cnt          <= '0;
              sof_timeout_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          FRAME_RUN: begin
            to_cnt <= '0;
          end
          default: begin
            state <= IDLE;
            sof   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sof_frame_timer.sv
// Directed self-checking bench for sof_frame_timer (FRAME_CYCLES=100, EOF_GUARD=10, SOF_TIMEOUT=8).
module tb_sof_frame_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        frnum_load = 1'b0;
  logic [10:0] frnum_load_val = '0;
  logic        sof_done = 1'b0;
`ifdef SOF_FRAME_ADJ_EN
  logic [7:0]  sof_modify = 8'd64;
`endif
  logic        sof;
  logic [10:0] frame_no;
  logic        frame_start;
  logic        eof_window;
  logic        frame_rollover;
  logic        sof_timeout_err;
  logic [15:0] cycles_left;

  int checks = 0;
  int failures = 0;

  sof_frame_timer #(
    .FRAME_CYCLES (100),
    .EOF_GUARD    (10),
    .SOF_TIMEOUT  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .frnum_load      (frnum_load),
    .frnum_load_val  (frnum_load_val),
    .sof_done        (sof_done),
`ifdef SOF_FRAME_ADJ_EN
    .sof_modify      (sof_modify),
`endif
    .sof             (sof),
    .frame_no        (frame_no),
    .frame_start     (frame_start),
    .eof_window      (eof_window),
    .frame_rollover  (frame_rollover),
    .sof_timeout_err (sof_timeout_err),
    .cycles_left     (cycles_left)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    run   = 1'b0;
    tick(3);
    checks++;
    if ({sof, frame_start, eof_window, frame_rollover, sof_timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {sof, frame_start, eof_window, frame_rollover, sof_timeout_err});
    end
    checks++;
    if (frame_no !== 11'd0 || cycles_left !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts frame_no=%0d cycles_left=%0d exp=0/0", frame_no, cycles_left);
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (sof !== 1'b0 || cycles_left !== 16'd0 || eof_window !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset sof=%0b cycles_left=%0d eof=%0b exp=0/0/0",
               sof, cycles_left, eof_window);
    end
  endtask

  // Frame 0: run starts it, sof_done at cycle 4, next frame_start 100 cycles later.
  task automatic test_basic_frame;
    int n;
    run = 1'b1;
    tick(1);
    checks++;
    if (sof !== 1'b1 || frame_start !== 1'b1 || frame_no !== 11'd0 || cycles_left !== 16'd99) begin
      failures++;
      $display("FAIL first_sof sof=%0b fs=%0b frame_no=%0d left=%0d exp=1/1/0/99",
               sof, frame_start, frame_no, cycles_left);
    end
    tick(1);
    checks++;
    if (frame_start !== 1'b0 || sof !== 1'b1) begin
      failures++;
      $display("FAIL fs_pulse_width fs=%0b sof=%0b exp=0/1", frame_start, sof);
    end
    tick(2);
    sof_done = 1'b1;
    tick(1);
    sof_done = 1'b0;
    checks++;
    if (sof !== 1'b0 || cycles_left !== 16'd95 || sof_timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL sof_drop sof=%0b left=%0d err=%0b exp=0/95/0", sof, cycles_left, sof_timeout_err);
    end
    n = 4;
    while (frame_start !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (n !== 100 || frame_no !== 11'd1 || sof !== 1'b1) begin
      failures++;
      $display("FAIL frame_period got=%0d frame_no=%0d sof=%0b exp=100/1/1", n, frame_no, sof);
    end
  endtask

  // Frame 1: no sof_done; sof for 8 cycles, one error pulse, frame still 100 long.
  task automatic test_timeout;
    int hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (sof === 1'b1 && sof_timeout_err === 1'b0) hi++;
      tick(1);
    end
    checks++;
    if (hi !== 8) begin
      failures++;
      $display("FAIL timeout_sof_high got=%0d exp=8", hi);
    end
    checks++;
    if (sof !== 1'b0 || sof_timeout_err !== 1'b1 || cycles_left !== 16'd91) begin
      failures++;
      $display("FAIL timeout_pulse sof=%0b err=%0b left=%0d exp=0/1/91", sof, sof_timeout_err, cycles_left);
    end
    tick(1);
    checks++;
    if (sof_timeout_err !== 1'b0 || sof !== 1'b0) begin
      failures++;
      $display("FAIL timeout_single err=%0b sof=%0b exp=0/0", sof_timeout_err, sof);
    end
  endtask

  task automatic test_eof_window;
    tick(80);
    checks++;
    if (cycles_left !== 16'd10 || eof_window !== 1'b0) begin
      failures++;
      $display("FAIL eof_at10 left=%0d eof=%0b exp=10/0", cycles_left, eof_window);
    end
    tick(1);
    checks++;
    if (cycles_left !== 16'd9 || eof_window !== 1'b1) begin
      failures++;
      $display("FAIL eof_at9 left=%0d eof=%0b exp=9/1", cycles_left, eof_window);
    end
    tick(9);
    checks++;
    if (cycles_left !== 16'd0 || eof_window !== 1'b1 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL eof_at0 left=%0d eof=%0b fs=%0b exp=0/1/0", cycles_left, eof_window, frame_start);
    end
    tick(1);
    checks++;
    if (eof_window !== 1'b0 || frame_start !== 1'b1 || frame_no !== 11'd2 || cycles_left !== 16'd99) begin
      failures++;
      $display("FAIL eof_reload eof=%0b fs=%0b frame_no=%0d left=%0d exp=0/1/2/99",
               eof_window, frame_start, frame_no, cycles_left);
    end
  endtask

  // Frame 2: run drops at counter 50, frnum_load mid-frame ignored, then idle.
  task automatic test_run_drop;
    int bad = 0;
    sof_done = 1'b1;
    tick(1);
    sof_done = 1'b0;
    tick(48);
    checks++;
    if (cycles_left !== 16'd50) begin
      failures++;
      $display("FAIL run_drop_pos left=%0d exp=50", cycles_left);
    end
    run = 1'b0;
    frnum_load = 1'b1;
    frnum_load_val = 11'd5;
    tick(1);
    frnum_load = 1'b0;
    checks++;
    if (frame_no !== 11'd2 || cycles_left !== 16'd49) begin
      failures++;
      $display("FAIL frnum_ignored frame_no=%0d left=%0d exp=2/49", frame_no, cycles_left);
    end
    tick(49);
    checks++;
    if (sof !== 1'b0 || eof_window !== 1'b1 || cycles_left !== 16'd0) begin
      failures++;
      $display("FAIL run_drop_end sof=%0b eof=%0b left=%0d exp=0/1/0", sof, eof_window, cycles_left);
    end
    tick(1);
    checks++;
    if (sof !== 1'b0 || frame_start !== 1'b0 || eof_window !== 1'b0 || cycles_left !== 16'd0 ||
        frame_no !== 11'd3) begin
      failures++;
      $display("FAIL stop_idle sof=%0b fs=%0b eof=%0b left=%0d frame_no=%0d exp=0/0/0/0/3",
               sof, frame_start, eof_window, cycles_left, frame_no);
    end
    for (int k = 0; k < 150; k++) begin
      if (sof !== 1'b0 || eof_window !== 1'b0 || frame_start !== 1'b0 || cycles_left !== 16'd0) bad++;
      tick(1);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle_quiet active_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_rollover;
    frnum_load = 1'b1;
    frnum_load_val = 11'd2047;
    tick(1);
    frnum_load = 1'b0;
    checks++;
    if (frame_no !== 11'd2047 || sof !== 1'b0) begin
      failures++;
      $display("FAIL frnum_load frame_no=%0d sof=%0b exp=2047/0", frame_no, sof);
    end
    run = 1'b1;
    tick(1);
    checks++;
    if (frame_start !== 1'b1 || frame_no !== 11'd2047) begin
      failures++;
      $display("FAIL load_start fs=%0b frame_no=%0d exp=1/2047", frame_start, frame_no);
    end
    sof_done = 1'b1;
    tick(1);
    sof_done = 1'b0;
    tick(98);
    checks++;
    if (cycles_left !== 16'd0 || frame_rollover !== 1'b0 || frame_no !== 11'd2047) begin
      failures++;
      $display("FAIL pre_roll left=%0d roll=%0b frame_no=%0d exp=0/0/2047",
               cycles_left, frame_rollover, frame_no);
    end
    tick(1);
    checks++;
    if (frame_no !== 11'd0 || frame_rollover !== 1'b1 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL rollover frame_no=%0d roll=%0b fs=%0b exp=0/1/1", frame_no, frame_rollover, frame_start);
    end
    tick(1);
    checks++;
    if (frame_rollover !== 1'b0 || frame_no !== 11'd0) begin
      failures++;
      $display("FAIL roll_single roll=%0b frame_no=%0d exp=0/0", frame_rollover, frame_no);
    end
  endtask

  // Reset asserted mid-cycle while sof is high clears outputs without a clock edge.
  task automatic test_reset_mid;
    checks++;
    if (sof !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_sof got=%0b exp=1", sof);
    end
    #3;
    reset = 1'b0;
    run = 1'b0;
    #1;
    checks++;
    if ({sof, frame_start, eof_window, frame_rollover, sof_timeout_err} !== 5'b0 ||
        frame_no !== 11'd0 || cycles_left !== 16'd0) begin
      failures++;
      $display("FAIL async_reset flags=%b frame_no=%0d left=%0d exp=00000/0/0",
               {sof, frame_start, eof_window, frame_rollover, sof_timeout_err}, frame_no, cycles_left);
    end
    tick(2);
    reset = 1'b1;
    tick(3);
    checks++;
    if (sof !== 1'b0 || frame_start !== 1'b0 || cycles_left !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_idle sof=%0b fs=%0b left=%0d exp=0/0/0", sof, frame_start, cycles_left);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic_frame;
    test_timeout;
    test_eof_window;
    test_run_drop;
    test_rollover;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
